// File: rtl/tlv5618_slave.sv
// tlv5618_slave
// Device-side receiver for the TLV5618 three-wire serial DAC interface.
// Samples the link in the clk domain, assembles 16-bit words MSB first on
// DAC_sclk falling edges and decodes them into the TLV5618 register model.
//
// Build option: define TLV5618_SLAVE_SYNC_EN for a two-flop synchroniser on
// every link pin. Leave it undefined only when the link is synchronous to clk.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   DAC_cs_n    frame select, active low (async to clk)
//   DAC_sclk    serial clock (async to clk)
//   DAC_din     serial data, captured at DAC_sclk falling edge
//   word        last complete word received
//   word_valid  one-cycle pulse when a word is accepted
//   frame_err   one-cycle pulse on a short frame or an overrun frame
//   dac_a       DAC A output latch
//   dac_b       DAC B output latch
//   buffer      double-buffer register
//   spd         speed bit (1 = fast)
//   pwr         power-down bit (1 = powered down)
//   busy        high while the synchronised frame select is low
module tlv5618_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DAC_cs_n,
  input  logic        DAC_sclk,
  input  logic        DAC_din,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        frame_err,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] buffer,
  output logic        spd,
  output logic        pwr,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic cs_sync_s;
  logic sclk_sync_s;
  logic din_sync_s;
  logic busy_r;

`ifdef TLV5618_SLAVE_SYNC_EN
  logic [1:0] cs_meta_r;
  logic [1:0] sclk_meta_r;
  logic [1:0] din_meta_r;

  // Two-flop synchroniser per pin; busy is taken off the same final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_r   <= 2'b11;
      sclk_meta_r <= 2'b11;
      din_meta_r  <= 2'b00;
      busy_r      <= 1'b0;
    end else begin
      cs_meta_r   <= {cs_meta_r[0], DAC_cs_n};
      sclk_meta_r <= {sclk_meta_r[0], DAC_sclk};
      din_meta_r  <= {din_meta_r[0], DAC_din};
      busy_r      <= ~cs_meta_r[0];
    end
  end

  assign cs_sync_s   = cs_meta_r[1];
  assign sclk_sync_s = sclk_meta_r[1];
  assign din_sync_s  = din_meta_r[1];
`else
  logic cs_in_r;
  logic sclk_in_r;
  logic din_in_r;

  // Single input register per pin for benches driving the link from clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_in_r   <= 1'b1;
      sclk_in_r <= 1'b1;
      din_in_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      cs_in_r   <= DAC_cs_n;
      sclk_in_r <= DAC_sclk;
      din_in_r  <= DAC_din;
      busy_r    <= ~DAC_cs_n;
    end
  end

  assign cs_sync_s   = cs_in_r;
  assign sclk_sync_s = sclk_in_r;
  assign din_sync_s  = din_in_r;
`endif

  logic cs_d_r;
  logic sclk_d_r;
  logic din_d_r;
  logic sclk_fall_r;
  logic cs_fall_r;
  logic cs_rise_r;

  // Edge detection; din is delayed alongside so it lines up with sclk_fall_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d_r      <= 1'b1;
      sclk_d_r    <= 1'b1;
      din_d_r     <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
    end else begin
      cs_d_r      <= cs_sync_s;
      sclk_d_r    <= sclk_sync_s;
      din_d_r     <= din_sync_s;
      sclk_fall_r <= sclk_d_r & ~sclk_sync_s;
      cs_fall_r   <= cs_d_r & ~cs_sync_s;
      cs_rise_r   <= ~cs_d_r & cs_sync_s;
    end
  end

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nxt_s;
  logic [15:0] shreg_r;
  logic [15:0] shreg_nxt_s;
  logic        overrun_r;
  logic        overrun_nxt_s;
  logic        accept_s;
  logic        err_s;

  // Frame FSM: next state, shift register, bit count and event pulses.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    shreg_nxt_s   = shreg_r;
    overrun_nxt_s = overrun_r;
    accept_s      = 1'b0;
    err_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_r) begin
          state_nxt_s   = ST_SHIFT;
          cnt_nxt_s     = 5'd0;
          overrun_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (sclk_fall_r) begin
          shreg_nxt_s = {shreg_r[14:0], din_d_r};
          cnt_nxt_s   = cnt_r + 5'd1;
        end else begin
          shreg_nxt_s = shreg_r;
        end
        // A 16th fall wins over a simultaneous cs_n rise: the word stands.
        if (sclk_fall_r && (cnt_r == 5'd15)) begin
          accept_s    = 1'b1;
          state_nxt_s = cs_rise_r ? ST_IDLE : ST_HOLD;
        end else if (cs_rise_r) begin
          err_s       = (cnt_nxt_s != 5'd0);
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (sclk_fall_r) begin
          overrun_nxt_s = 1'b1;
        end else begin
          overrun_nxt_s = overrun_r;
        end
        if (cs_rise_r) begin
          err_s       = overrun_r | sclk_fall_r;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  logic [15:0] word_r;
  logic        word_valid_r;
  logic        frame_err_r;
  logic [11:0] dac_a_r;
  logic [11:0] dac_b_r;
  logic [11:0] buffer_r;
  logic        spd_r;
  logic        pwr_r;

  // State registers and register-model update on an accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 5'd0;
      shreg_r      <= 16'h0000;
      overrun_r    <= 1'b0;
      word_r       <= 16'h0000;
      word_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      dac_a_r      <= 12'h000;
      dac_b_r      <= 12'h000;
      buffer_r     <= 12'h000;
      spd_r        <= 1'b0;
      pwr_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      shreg_r      <= shreg_nxt_s;
      overrun_r    <= overrun_nxt_s;
      word_valid_r <= accept_s;
      frame_err_r  <= err_s;
      if (accept_s) begin
        word_r <= shreg_nxt_s;
        spd_r  <= shreg_nxt_s[14];
        pwr_r  <= shreg_nxt_s[13];
        // Register select is {R1, R0} = {D15, D12}.
        case ({shreg_nxt_s[15], shreg_nxt_s[12]})
          2'b00: begin
            dac_b_r  <= shreg_nxt_s[11:0];
            buffer_r <= shreg_nxt_s[11:0];
          end
          2'b01: begin
            buffer_r <= shreg_nxt_s[11:0];
          end
          2'b10: begin
            dac_a_r <= shreg_nxt_s[11:0];
            dac_b_r <= buffer_r;
          end
          default: begin
            dac_a_r <= dac_a_r;
          end
        endcase
      end else begin
        word_r <= word_r;
      end
    end
  end

  assign word       = word_r;
  assign word_valid = word_valid_r;
  assign frame_err  = frame_err_r;
  assign dac_a      = dac_a_r;
  assign dac_b      = dac_b_r;
  assign buffer     = buffer_r;
  assign spd        = spd_r;
  assign pwr        = pwr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tlv5618_slave.sv
// Self-checking bench for tlv5618_slave: directed frames followed by random
// frames, compared against a behavioural TLV5618 register model.
module tb_tlv5618_slave;

`ifdef TLV5618_SLAVE_SYNC_EN
  localparam int LAT = 4;
  localparam int BUSY_LAT = 2;
`else
  localparam int LAT = 3;
  localparam int BUSY_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DAC_cs_n = 1'b1;
  logic        DAC_sclk = 1'b1;
  logic        DAC_din = 1'b0;
  logic [15:0] word;
  logic        word_valid;
  logic        frame_err;
  logic [11:0] dac_a;
  logic [11:0] dac_b;
  logic [11:0] buffer;
  logic        spd;
  logic        pwr;
  logic        busy;

  tlv5618_slave dut (
    .clk(clk), .rst_n(rst_n), .DAC_cs_n(DAC_cs_n), .DAC_sclk(DAC_sclk),
    .DAC_din(DAC_din), .word(word), .word_valid(word_valid),
    .frame_err(frame_err), .dac_a(dac_a), .dac_b(dac_b), .buffer(buffer),
    .spd(spd), .pwr(pwr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: cumulative counts and the cycle of the latest pulse.
  int wv_total = 0;
  int fe_total = 0;
  int both_total = 0;
  int wv_cyc = 0;
  int fe_cyc = 0;
  always @(negedge clk) begin
    if (word_valid) begin wv_total++; wv_cyc = cyc; end
    if (frame_err) begin fe_total++; fe_cyc = cyc; end
    if (word_valid && frame_err) both_total++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference register model.
  logic [15:0] m_word;
  logic [11:0] m_dac_a, m_dac_b, m_buf;
  logic        m_spd, m_pwr;

  task automatic model_reset();
    m_word = 16'h0; m_dac_a = 12'h0; m_dac_b = 12'h0; m_buf = 12'h0;
    m_spd = 1'b0; m_pwr = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] w);
    int sel;
    logic [11:0] d;
    sel = (w[15] ? 2 : 0) + (w[12] ? 1 : 0);
    d = w[11:0];
    if (sel == 0) begin m_dac_b = d; m_buf = d; end
    else if (sel == 1) m_buf = d;
    else if (sel == 2) begin m_dac_b = m_buf; m_dac_a = d; end
    m_spd = w[14];
    m_pwr = w[13];
    m_word = w;
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_word"}, {16'h0, word}, {16'h0, m_word});
    check_eq({tag, "_dac_a"}, {20'h0, dac_a}, {20'h0, m_dac_a});
    check_eq({tag, "_dac_b"}, {20'h0, dac_b}, {20'h0, m_dac_b});
    check_eq({tag, "_buffer"}, {20'h0, buffer}, {20'h0, m_buf});
    check_eq({tag, "_spd"}, {31'h0, spd}, {31'h0, m_spd});
    check_eq({tag, "_pwr"}, {31'h0, pwr}, {31'h0, m_pwr});
  endtask

  // Sends one frame of nfalls sclk falls (bits beyond 16 are zero) and
  // checks pulses, latencies and the register model afterwards.
  task automatic send_frame(input string tag, input logic [15:0] w, input int nfalls,
                            input bit cs_with_last);
    int wv0, fe0, both0, fall16_cyc, rise_cyc, cs_fall_cyc;
    bit exp_acc, exp_fe;
    wv0 = wv_total; fe0 = fe_total; both0 = both_total;
    fall16_cyc = 0;
    @(negedge clk);
    DAC_cs_n = 1'b0; DAC_sclk = 1'b1;
    cs_fall_cyc = cyc;
    repeat (4) @(negedge clk);
    check_eq({tag, "_busy_hi"}, {31'h0, busy}, 32'h1);
    for (int i = 0; i < nfalls; i++) begin
      DAC_din = (i < 16) ? w[15 - i] : 1'b0;
      DAC_sclk = 1'b1;
      repeat (3) @(negedge clk);
      DAC_sclk = 1'b0;
      if (i == 15) fall16_cyc = cyc;
      if (cs_with_last && (i == nfalls - 1)) DAC_cs_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    if (!cs_with_last) begin
      DAC_cs_n = 1'b1;
    end
    rise_cyc = cyc;
    repeat (8) @(negedge clk);
    exp_acc = (nfalls >= 16);
    exp_fe  = ((nfalls > 0) && (nfalls < 16)) || (nfalls > 16);
    if (exp_acc) model_apply(w);
    check_eq({tag, "_wv_pulses"}, wv_total - wv0, exp_acc ? 32'd1 : 32'd0);
    check_eq({tag, "_fe_pulses"}, fe_total - fe0, exp_fe ? 32'd1 : 32'd0);
    check_eq({tag, "_both"}, both_total - both0, 32'd0);
    if (exp_acc) check_eq({tag, "_wv_lat"}, wv_cyc - fall16_cyc, LAT);
    if (exp_fe) check_eq({tag, "_fe_lat"}, fe_cyc - rise_cyc, LAT);
    check_eq({tag, "_busy_lo"}, {31'h0, busy}, 32'h0);
    check_regs(tag);
    if (cs_fall_cyc < 0) check_eq({tag, "_never"}, 32'h0, 32'h1);
  endtask

  initial begin
    int wv0, fe0, nf, busy_seen;
    logic [15:0] rw;
    bit cwl;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("reset");
    check_eq("reset_wv", {31'h0, word_valid}, 32'h0);
    check_eq("reset_fe", {31'h0, frame_err}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // busy latency relative to cs_n at the pin
    DAC_cs_n = 1'b0;
    busy_seen = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (busy && busy_seen < 0) busy_seen = i;
    end
    check_eq("busy_lat", busy_seen, BUSY_LAT);
    DAC_cs_n = 1'b1;
    repeat (6) @(negedge clk);

    send_frame("w57D0", 16'h57D0, 16, 1'b0);
    check_eq("w57D0_buf_const", {20'h0, buffer}, 32'h7D0);
    send_frame("wC3E8", 16'hC3E8, 16, 1'b0);
    check_eq("wC3E8_dac_a_const", {20'h0, dac_a}, 32'h3E8);
    check_eq("wC3E8_dac_b_const", {20'h0, dac_b}, 32'h7D0);
    send_frame("w2123", 16'h2123, 16, 1'b0);
    check_eq("w2123_dac_b_const", {20'h0, dac_b}, 32'h123);
    send_frame("w9ABC", 16'h9ABC, 16, 1'b0);
    check_eq("w9ABC_word_const", {16'h0, word}, 32'h9ABC);
    send_frame("short9", 16'hFFFF, 9, 1'b0);
    send_frame("w0055", 16'h0055, 16, 1'b0);
    check_eq("w0055_dac_b_const", {20'h0, dac_b}, 32'h055);
    send_frame("over18", 16'h1456, 18, 1'b0);
    check_eq("over18_buf_const", {20'h0, buffer}, 32'h456);
    send_frame("cs_same", 16'h0A5A, 16, 1'b1);
    send_frame("empty", 16'h0000, 0, 1'b0);

    // Reset in the middle of a frame
    wv0 = wv_total; fe0 = fe_total;
    @(negedge clk);
    DAC_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      DAC_din = i[0]; DAC_sclk = 1'b1;
      repeat (3) @(negedge clk);
      DAC_sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_regs("midrst_in");
    check_eq("midrst_busy", {31'h0, busy}, 32'h0);
    DAC_cs_n = 1'b1; DAC_sclk = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check_regs("midrst_out");
    check_eq("midrst_wv", wv_total - wv0, 32'd0);
    check_eq("midrst_fe", fe_total - fe0, 32'd0);

    // Random frames
    for (int n = 0; n < 40; n++) begin
      int sel;
      rw = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 7) nf = 16;
      else if (sel == 7) nf = $urandom_range(0, 15);
      else nf = $urandom_range(17, 18);
      cwl = (nf == 16) && ($urandom_range(0, 4) == 0);
      send_frame("rand", rw, nf, cwl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/tlv5618_slave.md
# tlv5618_slave

Clocked receiver for the TLV5618 three-wire serial interface: the device end of the link driven by our DAC driver. Samples DAC_cs_n/DAC_sclk/DAC_din in the system clock domain, assembles 16-bit control words MSB first on SCLK falling edges, and decodes them into the TLV5618 register model: DAC A, DAC B, double buffer, speed and power-down. Used as a loopback checker on FPGA and as a bench responder for the driver.

## Interface
- No parameters.
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- DAC_cs_n  input  1  frame select, active low, asynchronous to clk
- DAC_sclk  input  1  serial clock, asynchronous to clk
- DAC_din  input  1  serial data, sampled on DAC_sclk falling edge
- word  output  16  last complete word received
- word_valid  output  1  one-cycle pulse when a complete word is accepted
- frame_err  output  1  one-cycle pulse on a bad frame
- dac_a  output  12  DAC A output latch
- dac_b  output  12  DAC B output latch
- buffer  output  12  double-buffer register
- spd  output  1  speed bit (1 = fast)
- pwr  output  1  power-down bit (1 = powered down)
- busy  output  1  high while a frame is open (synchronised cs_n low)

## Operation
- Inputs pass through the synchroniser (see Configuration); one further register on sclk/cs_n gives edge detection. din uses the same pipeline depth as sclk so alignment is preserved.
- States: IDLE, SHIFT, HOLD.
  - IDLE: synchronised cs_n falling -> SHIFT, bit count cleared to 0.
  - SHIFT: each synchronised sclk falling edge shifts din into a 16-bit register (MSB first), count+1. On the 16th edge: latch word, decode, pulse word_valid, -> HOLD.
  - HOLD: wait for cs_n high -> IDLE. Further sclk falls ignored, overrun flag set.
  - cs_n rising in SHIFT with count 1..15 -> frame_err pulse, word discarded, no register change, -> IDLE. cs_n rising in SHIFT with count 0 -> IDLE silently. cs_n rising in HOLD with overrun set -> frame_err pulse (decoded word stands).
- Decode of word: D15=R1, D14=SPD, D13=PWR, D12=R0, D11..0=data.
  - R1R0=00: dac_b<=data, buffer<=data.
  - R1R0=01: buffer<=data.
  - R1R0=10: dac_a<=data, dac_b<=buffer (pre-update value).
  - R1R0=11: reserved; no latch changes.
  - spd<=D14, pwr<=D13 for every accepted word, including reserved.
- sclk idle level is don't-care; only falls while frame open count.

## Timing
- Reset: word=0, word_valid=0, frame_err=0, dac_a=0, dac_b=0, buffer=0, spd=0, pwr=0, busy=0, state IDLE, count 0. Reset mid-frame aborts with no pulses.
- Latency: word, latches and word_valid update on the 4th rising clk edge after the 16th DAC_sclk fall at the pin (3rd when synchroniser disabled). frame_err same latency relative to cs_n rise. busy follows cs_n with 2 (1) cycle delay.
- Input requirements: sclk high and low phases ≥3 clk periods; din stable ≥2 clk periods before and after each sclk fall; cs_n high ≥3 clk periods between frames.
- cs_n rise and 16th sclk fall detected in same cycle: word accepted, no frame_err.
- word_valid and frame_err never assert in the same cycle, except HOLD-overrun cannot coincide with acceptance by construction.

## Configuration
- TLV5618_SLAVE_SYNC_EN defined: two-flop synchroniser on each of DAC_cs_n, DAC_sclk, DAC_din (latency per Timing, 4 edges).
- Undefined: single input register per pin (3 edges); only for benches where inputs are synchronous to clk.

## Test plan
- Reset then word 0x57D0 -> buffer=0x7D0, spd=1, pwr=0, dac_a=dac_b=0, word_valid one pulse, word=0x57D0.
- Follow with 0xC3E8 -> dac_a=0x3E8, dac_b=0x7D0, spd=1, buffer unchanged 0x7D0.
- Word 0x2123 -> dac_b=0x123, buffer=0x123, pwr=1, spd=0.
- Reserved 0x9ABC -> word_valid, word=0x9ABC, spd=0, pwr=0, dac_a/dac_b/buffer unchanged.
- cs_n raised after 9 sclk falls -> frame_err one pulse, no word_valid, all latches unchanged; next full 0x0055 frame accepted (dac_b=0x055).
- 18 sclk falls in one frame of 0x1456 -> word_valid after 16th (buffer=0x456), frame_err at cs_n rise; rst_n pulsed mid-frame -> all outputs return to reset values.
